// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver (majority vote, parity/stop checks,
// break detect) feeding an error-tagged receive FIFO. Defining
// UART_RX_TIMEOUT_EN adds an idle character-timeout pulse on rx_timeout.
module uart_rx_ovs #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          d_out,
    output logic [1:0]                    d_err,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          rx_error,
    output logic                          parity_error,
    output logic                          fifo_overflow,
    output logic                          break_det,
    output logic                          rx_timeout
);
    localparam int DIV = (CLOCK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int TW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int BW  = $clog2(DATA_BITS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int EW  = DATA_BITS + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic                 rx_m, rx_s, rx_p;
    logic                 fall, start_det;
    logic [2:0]           state;
    logic [SW-1:0]        samp_cnt, samp_nxt, hi_cnt;
    logic                 v0, v1, maj, mid;
    logic [DATA_BITS-1:0] data;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 perr, ferr, ferr_fin, par_exp;
    logic                 frame_done;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 wr_ok, rd_ok;

    assign tick       = tick_cnt == TW'(DIV - 1);
    assign fall       = rx_p & ~rx_s;
    assign start_det  = state == S_IDLE && fall;
    assign samp_nxt   = samp_cnt == SW'(OVERSAMPLE - 1) ? '0 : samp_cnt + 1'b1;
    assign mid        = tick && samp_nxt == SW'(M + 1);
    assign maj        = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
    assign par_exp    = PARITY == 1 ? ~^data : ^data;
    assign ferr_fin   = ferr | ~maj;
    assign frame_done = state == S_STOP && mid && stop_idx == 1'(STOP_BITS - 1);
    assign break_det  = state == S_BREAK;
    assign empty      = count == '0;
    assign full       = count == CW'(FIFO_DEPTH);
    assign rd_ok      = rd_en && !empty;
    assign wr_ok      = frame_done && (!full || rd_en);

    // Free-running oversample tick divider
    always_ff @(posedge clk)
        if (rst) tick_cnt <= '0;
        else     tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

    // Two-flop synchroniser plus delayed copy for falling-edge detection
    always_ff @(posedge clk)
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end

    // Sample phase tracking, majority sampling and frame-decoding state machine
    always_ff @(posedge clk)
        if (rst) begin
            state    <= S_IDLE;
            samp_cnt <= '0;
            hi_cnt   <= '0;
            v0       <= 1'b1;
            v1       <= 1'b1;
            data     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            samp_cnt <= start_det ? '0 : tick ? samp_nxt : samp_cnt;
            if (tick && samp_nxt == SW'(M - 1)) v0 <= rx_s;
            if (tick && samp_nxt == SW'(M))     v1 <= rx_s;
            hi_cnt <= state != S_BREAK || !rx_s ? '0 : tick ? hi_cnt + 1'b1 : hi_cnt;
            case (state)
                S_IDLE:
                    if (start_det) state <= S_START;
                S_START:
                    if (mid) begin
                        state   <= maj ? S_IDLE : S_DATA;
                        bit_idx <= '0;
                        perr    <= 1'b0;
                        ferr    <= 1'b0;
                    end
                S_DATA:
                    if (mid) begin
                        data    <= {maj, data[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            state    <= PARITY != 0 ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                        end
                    end
                S_PARITY:
                    if (mid) begin
                        perr  <= maj != par_exp;
                        state <= S_STOP;
                    end
                S_STOP:
                    if (mid) begin
                        ferr     <= ferr_fin;
                        stop_idx <= 1'b1;
                        if (frame_done) state <= data == '0 && ferr_fin ? S_BREAK : S_IDLE;
                    end
                S_BREAK:
                    if (tick && rx_s && hi_cnt == SW'(OVERSAMPLE - 1)) state <= S_IDLE;
                default:
                    state <= S_IDLE;
            endcase
        end

    // FIFO pointers, occupancy and registered read port
    always_ff @(posedge clk)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            d_out  <= '0;
            d_err  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr         <= rd_ptr + 1'b1;
                {d_err, d_out} <= mem[rd_ptr];
            end
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end

    // FIFO storage: {parity error, framing error, data} per entry
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= {perr, ferr_fin, data};

    // One-cycle status pulses for each completed frame
    always_ff @(posedge clk)
        if (rst) begin
            rx_error      <= 1'b0;
            parity_error  <= 1'b0;
            fifo_overflow <= 1'b0;
        end else begin
            rx_error      <= frame_done && ferr_fin;
            parity_error  <= frame_done && perr;
            fifo_overflow <= frame_done && full && !rd_en;
        end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_LIM = 4 * (1 + DATA_BITS + (PARITY != 0 ? 1 : 0) + STOP_BITS) * OVERSAMPLE;
    localparam int TOW    = $clog2(TO_LIM + 1);

    logic [TOW-1:0] to_cnt;
    logic           to_inc;

    assign to_inc = tick && state == S_IDLE && !empty && to_cnt != TOW'(TO_LIM);

    // Idle character timeout: counts ticks up to the limit once, then holds
    always_ff @(posedge clk)
        if (rst || rd_ok || start_det) begin
            to_cnt     <= '0;
            rx_timeout <= 1'b0;
        end else begin
            if (to_inc) to_cnt <= to_cnt + 1'b1;
            rx_timeout <= to_inc && to_cnt == TOW'(TO_LIM - 1);
        end
`else
    assign rx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: directed and randomized frames checked against a queue model
module tb_uart_rx_ovs;
    localparam int CLK_HZ = 100_000_000;
    localparam int BAUD   = 1_041_666;
    localparam int DB     = 8;
    localparam int PAR    = 2;
    localparam int SB     = 1;
    localparam int OS     = 16;
    localparam int DEPTH  = 16;
    localparam int BIT    = 960;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic rd_en = 1'b0;
    logic [DB-1:0] d_out;
    logic [1:0] d_err;
    logic empty, full;
    logic [$clog2(DEPTH):0] count;
    logic rx_error, parity_error, fifo_overflow, break_det, rx_timeout;

    always #5 clk = ~clk;

    uart_rx_ovs #(
        .CLOCK_FREQ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB), .PARITY(PAR),
        .STOP_BITS(SB), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en),
        .d_out(d_out), .d_err(d_err), .empty(empty), .full(full), .count(count),
        .rx_error(rx_error), .parity_error(parity_error), .fifo_overflow(fifo_overflow),
        .break_det(break_det), .rx_timeout(rx_timeout)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_ferr = 0, n_perr = 0, n_ovf = 0, n_to = 0;
    int e_ferr = 0, e_perr = 0, e_ovf = 0;
    logic [DB+1:0] q[$];

    always @(posedge clk) begin
        n_ferr <= n_ferr + int'(rx_error);
        n_perr <= n_perr + int'(parity_error);
        n_ovf  <= n_ovf + int'(fifo_overflow);
        n_to   <= n_to + int'(rx_timeout);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [DB-1:0] d, input bit pbad, input bit sbad);
        rx = 1'b0;
        #BIT;
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            #BIT;
        end
        if (PAR != 0) begin
            rx = (PAR == 1 ? ~^d : ^d) ^ pbad;
            #BIT;
        end
        for (int i = 0; i < SB; i++) begin
            rx = ~sbad;
            #BIT;
        end
        rx = 1'b1;
        #(2 * BIT);
        if (q.size() == DEPTH) e_ovf++;
        else q.push_back({pbad && PAR != 0, sbad, d});
        e_ferr += int'(sbad);
        e_perr += int'(pbad && PAR != 0);
    endtask

    task automatic pop(input string tag);
        logic [DB+1:0] e;
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
        e = q.pop_front();
        check({tag, "_data"}, 32'(d_out), 32'(e[DB-1:0]));
        check({tag, "_err"}, 32'(d_err), 32'(e[DB+1:DB]));
        check({tag, "_count"}, 32'(count), 32'(q.size()));
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_ferr_pulses"}, 32'(n_ferr), 32'(e_ferr));
        check({tag, "_perr_pulses"}, 32'(n_perr), 32'(e_perr));
        check({tag, "_ovf_pulses"}, 32'(n_ovf), 32'(e_ovf));
    endtask

    initial begin
        logic [DB-1:0] msg [5];
        logic [DB-1:0] d;
        bit pb, sb;
        int t0;
        msg[0] = 8'h48; msg[1] = 8'h45; msg[2] = 8'h4C; msg[3] = 8'h4C; msg[4] = 8'h4F;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_dout", 32'(d_out), 0);
        check("rst_derr", 32'(d_err), 0);
        check("rst_break", 32'(break_det), 0);
        check("rst_timeout", 32'(rx_timeout), 0);

        foreach (msg[i]) send(msg[i], 1'b0, 1'b0);
        check("hello_count", 32'(count), 5);
        check_pulses("hello");
        for (int i = 0; i < 5; i++) pop("hello");
        check("hello_empty", 32'(empty), 1);

        for (int i = 0; i < 8; i++) begin
            d  = DB'($urandom);
            pb = $urandom_range(0, 3) == 0;
            sb = $urandom_range(0, 3) == 0;
            if (sb && d == '0) d = 8'h5A;
            send(d, pb, sb);
        end
        check("rand_count", 32'(count), 32'(q.size()));
        check_pulses("rand");
        while (q.size() > 0) pop("rand");

        send(8'h41, 1'b1, 1'b0);
        check_pulses("parity");
        pop("parity");

        send(8'h42, 1'b0, 1'b1);
        check_pulses("frame");
        pop("frame");

        rx = 1'b0;
        #(20 * BIT);
        check("break_low", 32'(break_det), 1);
        rx = 1'b1;
        #(BIT / 2);
        check("break_hold", 32'(break_det), 1);
        #BIT;
        check("break_exit", 32'(break_det), 0);
        q.push_back({1'b0, 1'b1, 8'h00});
        e_ferr++;
        check_pulses("break");
        pop("break");

        for (int i = 0; i < DEPTH + 3; i++) begin
            send(8'h41, 1'b0, 1'b0);
            if (i == DEPTH - 2) check("ovf_not_full", 32'(full), 0);
            if (i == DEPTH - 1) check("ovf_full", 32'(full), 1);
        end
        check("ovf_count", 32'(count), DEPTH);
        check_pulses("ovf");
        for (int i = 0; i < DEPTH; i++) pop("ovf");
        check("ovf_empty", 32'(empty), 1);
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
        check("empty_rd_dout", 32'(d_out), 32'h41);
        check("empty_rd_count", 32'(count), 0);

        rx = 1'b0;
        #300;
        rx = 1'b1;
        #(3 * BIT);
        check("glitch_count", 32'(count), 0);
        check_pulses("glitch");
        send(8'h55, 1'b0, 1'b0);
        pop("glitch");

        send(8'h33, 1'b0, 1'b0);
        rx = 1'b0;
        #BIT;
        rx = 1'b1;
        #BIT;
        rx = 1'b0;
        #BIT;
        rx = 1'b1;
        #(BIT / 2);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        q.delete();
        check("mrst_count", 32'(count), 0);
        check("mrst_empty", 32'(empty), 1);
        check("mrst_dout", 32'(d_out), 0);
        #(12 * BIT);
        check("mrst_count_late", 32'(count), 0);
        check_pulses("mrst");
        send(8'hC3, 1'b0, 1'b0);
        check("after_rst_count", 32'(count), 1);
        t0 = n_to;
        #(50 * BIT);
`ifdef UART_RX_TIMEOUT_EN
        check("timeout_pulses", 32'(n_to - t0), 1);
`else
        check("timeout_pulses", 32'(n_to - t0), 0);
`endif
        pop("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
Parametrised successor to the single-mode UART receiver. It adds 16x oversampling with 3-sample majority vote, false-start rejection, configurable data width, parity and stop bits, break detection, and per-entry error status stored alongside each byte in the receive FIFO. It sits between the board rx pin and the host-side byte consumer, which drains the FIFO via rd_en.

Parameters:
CLOCK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked per frame; legal 1 or 2
OVERSAMPLE, 16, sample ticks per bit; legal 8 or 16
FIFO_DEPTH, 16, receive FIFO entries; power of 2, >= 2

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input; idle high
rd_en  in  1  pop one FIFO entry
d_out  out  DATA_BITS  data of last popped entry
d_err  out  2  status of last popped entry: [1] = parity error, [0] = framing error
empty  out  1  FIFO holds no entries
full  out  1  FIFO holds FIFO_DEPTH entries
count  out  $clog2(FIFO_DEPTH)+1  current number of entries
rx_error  out  1  1-cycle pulse: framing error on a completed frame
parity_error  out  1  1-cycle pulse: parity mismatch on a completed frame
fifo_overflow  out  1  1-cycle pulse: completed frame dropped because FIFO was full
break_det  out  1  high while a break condition persists
rx_timeout  out  1  see Optional Feature

Behaviour:
- Reset: FSM = IDLE; FIFO cleared; d_out = 0; d_err = 0; count = 0; empty = 1; full = 0; all pulses = 0; break_det = 0; synchroniser flops = 1. Reset mid-frame aborts the frame; nothing is written.
- rx passes through a 2-FF synchroniser (rx_s) before use.
- Tick generator: DIV = round(CLOCK_FREQ / (BAUD*OVERSAMPLE)); tick is asserted 1 cycle every DIV clocks. With defaults DIV = 54 and one bit = 864 clocks.
- The tick counter free-runs in all states. The sample counter (0..OVERSAMPLE-1) is zeroed on start-edge detection.
- Majority bit value = majority of rx_s at sample indices M-1, M, M+1, where M = OVERSAMPLE/2.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: rx_s falling edge -> START.
  - START: majority at mid-bit = 1 -> false start, back to IDLE, nothing written. Majority = 0 -> DATA.
  - DATA: DATA_BITS bits, LSB first, one majority sample each. Then -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: sampled bit is compared against computed odd/even parity of the data.
  - STOP: each of STOP_BITS samples must be 1; any 0 sets framing error. At the final stop bit's mid-sample the frame completes. -> IDLE, or -> BREAK if data == 0 and framing error.
  - BREAK: break_det = 1 until rx_s = 1 for one full bit time, then -> IDLE.
- Frame completion cycle:
  - Write {perr, ferr, data} to the FIFO. Frames with errors are still stored.
  - Pulse rx_error / parity_error in the same cycle.
  - If FIFO is full and rd_en is not asserted: drop the frame, pulse fifo_overflow, leave stored entries untouched.
- Read: rd_en && !empty pops the head entry. d_out and d_err update on the next clock edge (1-cycle latency) and hold until the next pop. rd_en while empty is ignored; d_out holds.
- Simultaneous write and read:
  - Full: the read frees the slot, the write is accepted, no overflow, count unchanged.
  - Empty: the write lands, the read is ignored, count becomes 1.
- Pointers wrap modulo FIFO_DEPTH; count is the authoritative full/empty source.

Optional Feature:
Macro UART_RX_TIMEOUT_EN.
- Defined: a character-timeout counter counts ticks while FSM = IDLE and FIFO is non-empty. It clears on any pop, on start-edge detection, and on reset. When it reaches 4*(1+DATA_BITS+(PARITY!=0)+STOP_BITS)*OVERSAMPLE ticks, rx_timeout pulses for 1 cycle. The counter then holds until cleared (no repeat pulse).
- Undefined: no timeout logic is built; rx_timeout is tied to 0.

Test Plan:
1. Defaults; send 0x48,0x45,0x4C,0x4C,0x4F at a 8681 ns bit period -> count = 5, no error pulses; five pops return those bytes in order with d_err = 00.
2. PARITY=2; send 0x41 with parity bit = 1 (wrong) -> parity_error pulses once; pop returns d_out = 0x41, d_err = 10.
3. Send 0x42 with stop bit = 0 -> rx_error pulse, d_err = 01. Then hold rx low for 20 bit times -> a 0x00 entry with d_err = 01, break_det high until rx returns high plus 1 bit time.
4. Send FIFO_DEPTH+3 bytes of 0x41 with no reads -> full asserts after 16 bytes, fifo_overflow pulses exactly 3 times, count = 16; 16 pops return 0x41, then empty = 1.
5. Drive a 3000 ns low glitch on idle rx -> no entry written, FSM returns to IDLE, and a following 0x55 frame is received correctly.
6. Assert rst for 1 cycle in the middle of DATA of frame 2 -> count = 0, empty = 1, no pulses. A frame sent afterwards is received correctly. With UART_RX_TIMEOUT_EN, 1 unread byte plus 40 idle bit times -> exactly one rx_timeout pulse.
